// File: rtl/mem_stage.sv
// Memory-access stage of nqcpu: runs byte/word loads and stores on a 16-bit,
// byte-enabled bus, splitting misaligned word accesses into two beats.
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] addr_in,
   input  logic [15:0] wdata_in,
   input  logic        memReadB,
   input  logic        memReadW,
   input  logic        memWriteB,
   input  logic        memWriteW,
   input  logic [32:0] ctrl_in,
   input  logic [15:0] pc_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] rdata_out,
   output logic [32:0] ctrl_out,
   output logic [15:0] pc_out,
   output logic        bus_req,
   output logic        bus_we,
   output logic [14:0] bus_addr,
   output logic [1:0]  bus_be,
   output logic [15:0] bus_wdata,
   input  logic [15:0] bus_rdata,
   input  logic        bus_ack
);

   typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, DONE} stateT;

   stateT       state;
   stateT       stateNext;

   logic        isLoad;
   logic        isWord;
   logic        oddAddr;
   logic [7:0]  wdataHigh;
   logic [7:0]  lowByte;

   logic        startAny;
   logic        startWrite;
   logic        startWord;
   logic        beatDone;
   logic        splitWord;

   logic        reqNext;
   logic        weNext;
   logic [14:0] addrNext;
   logic [1:0]  beNext;
   logic [15:0] wdataNext;
   logic        startLatch;
   logic        captureLow;
   logic        updateRdata;
   logic [15:0] loadResult;

   // Priority among the flags is writes over reads, words over bytes.
   assign startAny   = memWriteW | memWriteB | memReadW | memReadB;
   assign startWrite = memWriteW | memWriteB;
   assign startWord  = memWriteW | (~memWriteB & memReadW);

   assign beatDone   = bus_req & bus_ack;
   assign splitWord  = isWord & oddAddr;

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_comb begin
      stateNext   = state;
      reqNext     = bus_req;
      weNext      = bus_we;
      addrNext    = bus_addr;
      beNext      = bus_be;
      wdataNext   = bus_wdata;
      startLatch  = 1'b0;
      captureLow  = 1'b0;
      updateRdata = 1'b0;
      case (state)
         IDLE: begin
            if (en) begin
               startLatch = 1'b1;
               if (startAny) begin
                  stateNext = BEAT1;
                  reqNext   = 1'b1;
                  weNext    = startWrite;
                  addrNext  = addr_in[15:1];
                  if (startWord && !addr_in[0]) begin
                     beNext    = 2'b11;
                     wdataNext = wdata_in;
                  end else begin
                     beNext    = addr_in[0] ? 2'b10 : 2'b01;
                     wdataNext = {2{wdata_in[7:0]}};
                  end
               end else begin
                  stateNext = DONE;
               end
            end
         end
         BEAT1: begin
            if (beatDone) begin
               if (splitWord) begin
                  stateNext  = BEAT2;
                  addrNext   = bus_addr + 15'd1;
                  beNext     = 2'b01;
                  wdataNext  = {2{wdataHigh}};
                  captureLow = 1'b1;
               end else begin
                  stateNext   = DONE;
                  reqNext     = 1'b0;
                  updateRdata = isLoad;
               end
            end
         end
         BEAT2: begin
            if (beatDone) begin
               stateNext   = DONE;
               reqNext     = 1'b0;
               updateRdata = isLoad;
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Assemble the load value from the beat completing now (plus the saved low byte).
   always_comb begin
      if (splitWord) begin
         loadResult = {bus_rdata[7:0], lowByte};
      end else if (isWord) begin
         loadResult = bus_rdata;
      end else if (oddAddr) begin
         loadResult = {8'h00, bus_rdata[15:8]};
      end else begin
         loadResult = {8'h00, bus_rdata[7:0]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // rdata_out is written on the edge the last beat completes so it is valid with done.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= 15'd0;
         bus_be    <= 2'b00;
         bus_wdata <= 16'd0;
         rdata_out <= 16'd0;
         ctrl_out  <= 33'd0;
         pc_out    <= 16'd0;
         isLoad    <= 1'b0;
         isWord    <= 1'b0;
         oddAddr   <= 1'b0;
         wdataHigh <= 8'd0;
         lowByte   <= 8'd0;
      end else begin
         bus_req   <= reqNext;
         bus_we    <= weNext;
         bus_addr  <= addrNext;
         bus_be    <= beNext;
         bus_wdata <= wdataNext;
         if (startLatch) begin
            ctrl_out  <= ctrl_in;
            pc_out    <= pc_in;
            isLoad    <= startAny & ~startWrite;
            isWord    <= startWord;
            oddAddr   <= addr_in[0];
            wdataHigh <= wdata_in[15:8];
         end
         if (captureLow) begin
            lowByte <= bus_rdata[15:8];
         end
         if (updateRdata) begin
            rdata_out <= loadResult;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: byte-addressed memory model with configurable wait states,
// directed operations, and a per-cycle compare process.
module tb_mem_stage;

   logic        clk;
   logic        rst;
   logic        en;
   logic [15:0] addr_in;
   logic [15:0] wdata_in;
   logic        memReadB, memReadW, memWriteB, memWriteW;
   logic [32:0] ctrl_in;
   logic [15:0] pc_in;
   logic        busy, done;
   logic [15:0] rdata_out;
   logic [32:0] ctrl_out;
   logic [15:0] pc_out;
   logic        bus_req, bus_we;
   logic [14:0] bus_addr;
   logic [1:0]  bus_be;
   logic [15:0] bus_wdata;
   logic [15:0] bus_rdata;
   logic        bus_ack;

   int compared = 0;
   int mismatched = 0;

   logic [7:0]  memBytes [0:65535];
   int          waitCfg = 0;
   int          waitCnt = 0;
   bit          forceAck = 0;
   int          beatIdx = 0;

   bit          opActive = 0;
   int          cycleCnt = 0;
   int          doneCycle = -1;
   int          expN = 0;
   int          expDone = 0;
   bit          expWe = 0;
   logic [14:0] expAddr [2];
   logic [1:0]  expBe [2];
   logic [15:0] expData [2];
   logic [15:0] modelRdata = 16'd0;
   logic [32:0] expCtrl;
   logic [15:0] expPc;

   mem_stage dut (
      .clk(clk), .rst(rst), .en(en), .addr_in(addr_in), .wdata_in(wdata_in),
      .memReadB(memReadB), .memReadW(memReadW), .memWriteB(memWriteB), .memWriteW(memWriteW),
      .ctrl_in(ctrl_in), .pc_in(pc_in), .busy(busy), .done(done), .rdata_out(rdata_out),
      .ctrl_out(ctrl_out), .pc_out(pc_out), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Memory responder: acks after waitCfg wait cycles per beat, returns the addressed word.
   always @(negedge clk) begin
      bus_ack   = forceAck || (bus_req && (waitCnt >= waitCfg));
      bus_rdata = {memBytes[{bus_addr, 1'b1}], memBytes[{bus_addr, 1'b0}]};
   end

   always @(posedge clk) begin
      if (bus_req && bus_ack) begin
         if (bus_we && bus_be[0]) memBytes[{bus_addr, 1'b0}] = bus_wdata[7:0];
         if (bus_we && bus_be[1]) memBytes[{bus_addr, 1'b1}] = bus_wdata[15:8];
         beatIdx++;
         waitCnt = 0;
      end else if (bus_req) begin
         waitCnt++;
      end else begin
         waitCnt = 0;
      end
   end

   // Per-cycle comparison of DUT outputs against the expectations of the active op.
   always @(negedge clk) begin
      if (opActive) begin
         logic [15:0] mask;
         cycleCnt++;
         checkOutput("busy", busy, (cycleCnt <= expDone));
         checkOutput("done", done, (cycleCnt == expDone));
         if (done) begin
            doneCycle = cycleCnt;
            checkOutput("rdata_out", rdata_out, modelRdata);
            checkOutput("ctrl_out", ctrl_out, expCtrl);
            checkOutput("pc_out", pc_out, expPc);
            checkOutput("beatCount", beatIdx, expN);
         end
         if (bus_req) begin
            if (beatIdx < expN) begin
               checkOutput("beatWe", bus_we, expWe);
               checkOutput("beatAddr", bus_addr, expAddr[beatIdx]);
               checkOutput("beatBe", bus_be, expBe[beatIdx]);
               if (expWe) begin
                  mask = {{8{expBe[beatIdx][1]}}, {8{expBe[beatIdx][0]}}};
                  checkOutput("beatWdata", bus_wdata & mask, expData[beatIdx] & mask);
               end
            end else begin
               checkOutput("unexpectedReq", bus_req, 1'b0);
            end
         end
      end
   end

   // Starts one op at negedge+2, models it from byte-level rules, and returns
   // at negedge+2 of the cycle after done so the next op can start immediately.
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] wd, input logic [3:0] f,
                                input int waits, input logic [32:0] ctrl, input logic [15:0] pc,
                                input bit pulseEn, output int dc);
      int nBytes;
      bit isWrite;
      logic [15:0] b [2];
      logic [14:0] w;
      int lane;
      int k;
      nBytes = 0;
      isWrite = 0;
      if (f[3]) begin nBytes = 2; isWrite = 1; end
      else if (f[2]) begin nBytes = 1; isWrite = 1; end
      else if (f[1]) begin nBytes = 2; isWrite = 0; end
      else if (f[0]) begin nBytes = 1; isWrite = 0; end
      b[0] = a;
      b[1] = a + 16'd1;
      expN = 0;
      for (int i = 0; i < nBytes; i++) begin
         w = b[i][15:1];
         lane = int'(b[i][0]);
         if (expN == 0 || expAddr[expN-1] != w) begin
            expAddr[expN] = w;
            expBe[expN] = 2'b00;
            expData[expN] = 16'd0;
            expN++;
         end
         expBe[expN-1][lane] = 1'b1;
         expData[expN-1][lane*8 +: 8] = wd[i*8 +: 8];
      end
      if (nBytes > 0 && !isWrite)
         modelRdata = (nBytes == 2) ? {memBytes[b[1]], memBytes[b[0]]} : {8'h00, memBytes[b[0]]};
      expWe = isWrite;
      expDone = 1 + expN * (1 + waits);
      expCtrl = ctrl;
      expPc = pc;
      waitCfg = waits;
      beatIdx = 0;
      cycleCnt = 0;
      doneCycle = -1;
      opActive = 1;
      addr_in = a;
      wdata_in = wd;
      {memWriteW, memWriteB, memReadW, memReadB} = f;
      ctrl_in = ctrl;
      pc_in = pc;
      en = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
      if (pulseEn) begin
         en = 1'b1;
         {memWriteW, memWriteB, memReadW, memReadB} = 4'b0001;
         addr_in = 16'h0100;
         ctrl_in = ~ctrl;
         pc_in = ~pc;
         @(posedge clk); #1;
         en = 1'b0;
      end
      k = 0;
      while (cycleCnt < expDone + 1 && k < 200) begin
         @(negedge clk); #2;
         k++;
      end
      checkOutput("doneCycle", doneCycle, expDone);
      if (isWrite) begin
         for (int i = 0; i < nBytes; i++)
            checkOutput("memByte", memBytes[b[i]], wd[i*8 +: 8]);
      end
      dc = doneCycle;
   endtask

   initial begin
      int dc;
      logic [7:0] keep;
      for (int i = 0; i < 65536; i++) memBytes[i] = 8'(i * 13 + 7);
      memBytes[16'h0010] = 8'hEF; memBytes[16'h0011] = 8'hBE;
      memBytes[16'h0020] = 8'hC3; memBytes[16'h0021] = 8'hA5;
      memBytes[16'hFFFE] = 8'hAA; memBytes[16'hFFFF] = 8'h11;
      memBytes[16'h0000] = 8'hBB; memBytes[16'h0001] = 8'h22;
      rst = 1'b1; en = 1'b0; addr_in = '0; wdata_in = '0; ctrl_in = '0; pc_in = '0;
      {memWriteW, memWriteB, memReadW, memReadB} = 4'b0000;
      bus_ack = 1'b0; bus_rdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); #2;
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstDone", done, 0);
      checkOutput("rstReq", bus_req, 0);
      checkOutput("rstWe", bus_we, 0);
      checkOutput("rstAddr", bus_addr, 0);
      checkOutput("rstBe", bus_be, 0);
      checkOutput("rstWdata", bus_wdata, 0);
      checkOutput("rstRdata", rdata_out, 0);
      checkOutput("rstCtrl", ctrl_out, 0);
      checkOutput("rstPc", pc_out, 0);
      rst = 1'b0;

      $display("[TB] aligned word load");
      applyStimulus(16'h0010, 16'h0000, 4'b0010, 0, 33'h1_0000_0001, 16'h0100, 0, dc);
      checkOutput("litAlignedRdata", rdata_out, 16'hBEEF);
      checkOutput("litAlignedCycle", dc, 2);

      $display("[TB] misaligned word store");
      applyStimulus(16'h0011, 16'h1234, 4'b1000, 0, 33'h0_1234_5678, 16'h0102, 0, dc);
      checkOutput("litStoreLo", memBytes[16'h0011], 8'h34);
      checkOutput("litStoreHi", memBytes[16'h0012], 8'h12);
      checkOutput("litStoreCycle", dc, 3);
      checkOutput("litStoreKeepsRdata", rdata_out, 16'hBEEF);

      $display("[TB] byte load with 3 wait states");
      applyStimulus(16'h0021, 16'h0000, 4'b0001, 3, 33'h1_AAAA_5555, 16'h0104, 0, dc);
      checkOutput("litByteRdata", rdata_out, 16'h00A5);
      checkOutput("litByteCycle", dc, 5);

      $display("[TB] wrap-around misaligned load");
      applyStimulus(16'hFFFF, 16'h0000, 4'b0010, 0, 33'h0_0000_00FF, 16'h0106, 0, dc);
      checkOutput("litWrapRdata", rdata_out, 16'hBB11);

      $display("[TB] no-op");
      applyStimulus(16'h0123, 16'h4567, 4'b0000, 0, 33'h1_FFFF_0000, 16'h0108, 0, dc);
      checkOutput("litNoopCycle", dc, 1);
      checkOutput("litNoopRdata", rdata_out, 16'hBB11);

      $display("[TB] en ignored while busy");
      applyStimulus(16'h0031, 16'h0000, 4'b0010, 2, 33'h0_0F0F_0F0F, 16'h010A, 1, dc);
      checkOutput("litPulseCycle", dc, 7);

      $display("[TB] flag priority and store/load round trips");
      keep = memBytes[16'h0040];
      applyStimulus(16'h0041, 16'h00C7, 4'b0101, 1, 33'h0_0000_0041, 16'h010C, 0, dc);
      checkOutput("litPrioByte", memBytes[16'h0041], 8'hC7);
      checkOutput("litPrioNeighbour", memBytes[16'h0040], keep);
      applyStimulus(16'h0050, 16'h9A7B, 4'b1010, 1, 33'h1_0000_0050, 16'h010E, 0, dc);
      applyStimulus(16'h0050, 16'h0000, 4'b0010, 0, 33'h1_0000_0051, 16'h0110, 0, dc);
      checkOutput("litWordRoundTrip", rdata_out, 16'h9A7B);
      applyStimulus(16'h0060, 16'h33EE, 4'b0100, 0, 33'h0_0000_0060, 16'h0112, 0, dc);
      applyStimulus(16'h0060, 16'h0000, 4'b0001, 2, 33'h0_0000_0061, 16'h0114, 0, dc);
      checkOutput("litByteRoundTrip", rdata_out, 16'h00EE);

      $display("[TB] reset mid-beat");
      opActive = 0;
      waitCfg = 1000;
      addr_in = 16'h0070;
      {memWriteW, memWriteB, memReadW, memReadB} = 4'b0001;
      en = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
      @(negedge clk); #2;
      checkOutput("midReqBeforeRst", bus_req, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk); #2;
      checkOutput("midRstBusy", busy, 0);
      checkOutput("midRstReq", bus_req, 0);
      checkOutput("midRstDone", done, 0);
      checkOutput("midRstRdata", rdata_out, 0);
      modelRdata = 16'd0;
      forceAck = 1;
      @(negedge clk);
      @(posedge clk); #1;
      forceAck = 0;
      @(negedge clk); #2;
      checkOutput("lateAckBusy", busy, 0);
      checkOutput("lateAckDone", done, 0);
      checkOutput("lateAckReq", bus_req, 0);
      checkOutput("lateAckRdata", rdata_out, 0);

      applyStimulus(16'h0010, 16'h0000, 4'b0010, 1, 33'h1_2222_3333, 16'h0116, 0, dc);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
